// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, reset word and multi-cycle FSM states for pipe_ctrl
package pipe_ctrl_pkg;
   localparam logic [5:0] STALL_NONE    = 6'b000000;
   localparam logic [5:0] STALL_FROM_ID = 6'b000111;
   localparam logic [5:0] STALL_FROM_EX = 6'b001111;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   typedef enum logic {IDLE, MC_RUN} mc_state_t;
endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// pipe_ctrl_mc_timer: multi-cycle EX op timer (load / abort / down-counter)
//   start/cycles : begin an op needing `cycles` extra cycles (cycles==0 completes at once)
//   abort        : drop any running op, no done pulse
//   busy         : registered, high while in MC_RUN
//   done         : registered one-cycle completion pulse
//   hold         : combinational, op in flight this cycle (pipeline must hold EX and earlier)
module pipe_ctrl_mc_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] cycles,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   output logic         hold
);
   localparam logic [W-1:0] ONE = 1;
   mc_state_t state, state_nx;
   logic [W-1:0] cnt, cnt_nx;
   logic done_nx;
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      done_nx = 1'b0;
      if (abort) begin
         state_nx = IDLE;
         cnt_nx = '0;
      end else if (state == IDLE) begin
         if (start && cycles != '0) begin
            state_nx = MC_RUN;
            cnt_nx = cycles;
         end else if (start) begin
            done_nx = 1'b1;
         end
      end else begin
         cnt_nx = cnt - ONE;
         if (cnt == ONE) begin
            state_nx = IDLE;
            done_nx = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         done <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         done <= done_nx;
      end
   end
   assign busy = state == MC_RUN;
   // the start cycle itself already stalls when the op has extra cycles
   assign hold = busy || (start && cycles != '0);
   // starting a new op while one is running is a protocol error; it is ignored
   assert property (@(posedge clk) disable iff (rst) !(start && state == MC_RUN));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller (stall merge, multi-cycle timing, flush, stall perf counter)
//   stallreq_id/stallreq_ex : hazard hold requests (ex outranks id)
//   mc_start/mc_cycles      : multi-cycle EX op launch and its extra cycle count
//   flush_req/flush_pc      : exception/redirect; wins over every stall
//   stall[5:0]              : [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold
//   flush/new_pc            : clear stage registers and redirect PC this cycle
//   mc_busy/mc_done         : multi-cycle op running / completed pulse
//   stall_cycles            : saturating count of cycles with any stall
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_CNT_W   = 6,
   parameter int PERF_CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallreq_id,
   input  logic                  stallreq_ex,
   input  logic                  mc_start,
   input  logic [MC_CNT_W-1:0]   mc_cycles,
   input  logic                  flush_req,
   input  logic [31:0]           flush_pc,
   output logic [5:0]            stall,
   output logic                  flush,
   output logic [31:0]           new_pc,
   output logic                  mc_busy,
   output logic                  mc_done,
   output logic [PERF_CNT_W-1:0] stall_cycles
);
   localparam logic [PERF_CNT_W-1:0] PERF_ONE = 1;
   logic hold;
   pipe_ctrl_mc_timer #(.W(MC_CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (mc_start),
      .cycles (mc_cycles),
      .abort  (flush_req),
      .busy   (mc_busy),
      .done   (mc_done),
      .hold   (hold)
   );
   always_comb begin
      stall = (rst || flush_req) ? STALL_NONE :
              (hold || stallreq_ex) ? STALL_FROM_EX :
              stallreq_id ? STALL_FROM_ID : STALL_NONE;
      flush = !rst && flush_req;
      new_pc = flush ? flush_pc : ZERO_WORD;
   end
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall != STALL_NONE && stall_cycles != '1)
         stall_cycles <= stall_cycles + PERF_ONE;
   end
endmodule
